// File: rtl/frame_logger.sv
// frame_logger: periodic / triggered framed logger feeding a byte-wide UART.
// Frame = SYNC_BYTE, length, payload bytes 0..N-1, optional XOR checksum.
// The payload is snapshotted at frame start so it stays constant for the whole frame.
module frame_logger #(
    parameter int         NUM_BYTES       = 7,
    parameter int         UART_DATA_SIZE  = 8,
    parameter int         TICKS           = 60000000,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5,
    parameter int         ENABLE_CHECKSUM = 1,
    parameter int         PERIODIC        = 1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_trigger,
    input  logic [NUM_BYTES*8-1:0]      i_payload,
    input  logic                        i_txReady,
    output logic [UART_DATA_SIZE-1:0]   o_txData,
    output logic                        o_txValid,
    output logic                        o_busy,
    output logic [15:0]                 o_frameCount
);
    // Index of the final byte of a frame (checksum if enabled, else last payload byte).
    localparam int LAST_IDX = NUM_BYTES + 1 + ((ENABLE_CHECKSUM != 0) ? 1 : 0);
    localparam int IDX_W    = 8;
    localparam int CNT_W    = ($clog2(TICKS) < 1) ? 1 : $clog2(TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_END  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      pend_q, pend_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_BYTES*8-1:0]    snap_q, snap_d;
    logic [7:0]                chk_q, chk_d;
    logic [15:0]               fc_q, fc_d;

    logic start;
    logic xfer;
    logic last_xfer;

    // Frame start and byte-transfer qualifiers.
    always_comb begin
        start     = (state_q == ST_IDLE) && i_enable &&
                    (i_trigger || pend_q ||
                     ((PERIODIC != 0) && (cnt_q == CNT_W'(TICKS - 1))));
        xfer      = (state_q == ST_SEND) && i_txReady;
        last_xfer = xfer && (idx_q == IDX_W'(LAST_IDX));
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_SEND : ST_IDLE;
            ST_SEND: state_d = last_xfer ? ST_END : ST_SEND;
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: period counter, pending trigger, byte index, snapshot, count.
    always_comb begin
        cnt_d  = '0;
        pend_d = pend_q;
        idx_d  = idx_q;
        snap_d = snap_q;
        chk_d  = chk_q;
        fc_d   = fc_q;

        // Counter only runs while idle and enabled; it restarts on every return to IDLE.
        if ((state_q == ST_IDLE) && i_enable && !start)
            cnt_d = cnt_q + 1'b1;

        if ((state_q != ST_IDLE) && i_trigger)
            pend_d = 1'b1;

        if (start) begin
            pend_d = 1'b0;
            idx_d  = '0;
            snap_d = i_payload;
            chk_d  = 8'(NUM_BYTES);
            for (int k = 0; k < NUM_BYTES; k++)
                chk_d = chk_d ^ i_payload[8*k +: 8];
        end

        // A disabled logger forgets any queued trigger, even mid-frame.
        if (!i_enable)
            pend_d = 1'b0;

        if (xfer && !last_xfer)
            idx_d = idx_q + 1'b1;

        if (state_q == ST_END) begin
            idx_d = '0;
            fc_d  = fc_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            idx_q  <= '0;
            snap_q <= '0;
            chk_q  <= '0;
            fc_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            chk_q  <= chk_d;
            fc_q   <= fc_d;
        end
    end

    // Outputs decoded from state; data is zero whenever nothing is being offered.
    always_comb begin
        o_txData     = '0;
        o_txValid    = 1'b0;
        o_busy       = 1'b0;
        o_frameCount = fc_q;
        case (state_q)
            ST_SEND: begin
                o_txValid = 1'b1;
                o_busy    = 1'b1;
                if (idx_q == IDX_W'(0)) begin
                    o_txData = SYNC_BYTE;
                end else if (idx_q == IDX_W'(1)) begin
                    o_txData = 8'(NUM_BYTES);
                end else begin
                    o_txData = chk_q;
                    for (int k = 0; k < NUM_BYTES; k++)
                        if (idx_q == IDX_W'(k + 2))
                            o_txData = snap_q[8*k +: 8];
                end
            end
            ST_END:  o_busy = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_frame_logger.sv
// Randomized bench for frame_logger: two configurations (periodic+checksum,
// trigger-only without checksum) checked cycle by cycle against a frame-level model.
module tb_frame_logger;
  logic        clk = 1'b0;
  logic        rst, en, trig, rdy;
  logic [15:0] pay_a;
  logic [23:0] pay_b;
  logic [7:0]  da, db;
  logic        va, vb, ba, bb;
  logic [15:0] fca, fcb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_logger #(.NUM_BYTES(2), .UART_DATA_SIZE(8), .TICKS(4), .SYNC_BYTE(8'hA5),
                 .ENABLE_CHECKSUM(1), .PERIODIC(1)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_trigger(trig), .i_payload(pay_a),
    .i_txReady(rdy), .o_txData(da), .o_txValid(va), .o_busy(ba), .o_frameCount(fca));

  frame_logger #(.NUM_BYTES(3), .UART_DATA_SIZE(8), .TICKS(5), .SYNC_BYTE(8'hA5),
                 .ENABLE_CHECKSUM(0), .PERIODIC(0)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_trigger(trig), .i_payload(pay_b),
    .i_txReady(rdy), .o_txData(db), .o_txValid(vb), .o_busy(bb), .o_frameCount(fcb));

  // Reference model: per instance, a mode (0 idle, 1 sending, 2 end), the frame as a byte list.
  int          nb[2]    = '{2, 3};
  int          ticks[2] = '{4, 5};
  int          cks[2]   = '{1, 0};
  int          per[2]   = '{1, 0};
  int          mode[2], cnt[2], pos[2], len[2];
  logic        pend[2];
  logic [15:0] fc[2];
  logic [7:0]  frm[2][16];

  logic [7:0]  log_a[$], log_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input int i, input logic [31:0] pay);
    logic [7:0] x;
    if (rst) begin
      mode[i] = 0; cnt[i] = 0; pend[i] = 0; fc[i] = 0; pos[i] = 0;
      return;
    end
    case (mode[i])
      0: begin
        if (en && (trig || pend[i] || (per[i] != 0 && cnt[i] == ticks[i] - 1))) begin
          frm[i][0] = 8'hA5;
          frm[i][1] = 8'(nb[i]);
          x = 8'(nb[i]);
          for (int k = 0; k < nb[i]; k++) begin
            frm[i][2 + k] = 8'(pay >> (8 * k));
            x = x ^ frm[i][2 + k];
          end
          if (cks[i] != 0) frm[i][2 + nb[i]] = x;
          len[i]  = nb[i] + 2 + cks[i];
          pos[i]  = 0;
          mode[i] = 1;
          cnt[i]  = 0;
          pend[i] = 0;
        end else begin
          cnt[i] = en ? cnt[i] + 1 : 0;
          if (!en) pend[i] = 0;
        end
      end
      1: begin
        if (rdy) begin
          if (pos[i] == len[i] - 1) mode[i] = 2;
          else pos[i]++;
        end
        pend[i] = en ? (pend[i] | trig) : 1'b0;
      end
      default: begin
        fc[i]++;
        mode[i] = 0;
        pend[i] = en ? (pend[i] | trig) : 1'b0;
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, {16'h0, pay_a});
    model_step(1, {8'h0, pay_b});
    #1;
    chk("a_valid", {31'b0, va}, {31'b0, mode[0] == 1});
    chk("a_data",  {24'b0, da}, {24'b0, (mode[0] == 1) ? frm[0][pos[0]] : 8'h00});
    chk("a_busy",  {31'b0, ba}, {31'b0, mode[0] != 0});
    chk("a_count", {16'b0, fca}, {16'b0, fc[0]});
    chk("b_valid", {31'b0, vb}, {31'b0, mode[1] == 1});
    chk("b_data",  {24'b0, db}, {24'b0, (mode[1] == 1) ? frm[1][pos[1]] : 8'h00});
    chk("b_busy",  {31'b0, bb}, {31'b0, mode[1] != 0});
    chk("b_count", {16'b0, fcb}, {16'b0, fc[1]});
  endtask

  task automatic cycle_log();
    cycle();
    if (va && rdy) log_a.push_back(da);
    if (vb && rdy) log_b.push_back(db);
  endtask

  logic [7:0] exp_a[5] = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h24};
  logic [7:0] exp_b[5] = '{8'hA5, 8'h03, 8'h34, 8'h12, 8'h56};

  initial begin
    rst = 1'b1; en = 1'b0; trig = 1'b0; rdy = 1'b1;
    pay_a = 16'h1234; pay_b = 24'h561234;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; cnt[i] = 0; pos[i] = 0; len[i] = 0; pend[i] = 0; fc[i] = 0;
    end
    cycle(); cycle();
    rst = 1'b0; en = 1'b1;

    // Periodic frame on A after four idle cycles; B stays silent without a trigger.
    for (int n = 0; n < 12; n++) cycle_log();
    chk("a_frame_len", log_a.size(), 5);
    for (int k = 0; k < 5 && k < log_a.size(); k++) chk("a_frame_byte", {24'b0, log_a[k]}, {24'b0, exp_a[k]});
    chk("a_frames_done", {16'b0, fca}, 32'd1);
    chk("b_silent", log_b.size(), 0);

    // One trigger pulse: B sends a checksum-free frame, and nothing after it.
    trig = 1'b1; cycle_log(); trig = 1'b0;
    for (int n = 0; n < 20; n++) cycle_log();
    chk("b_frame_len", log_b.size(), 5);
    for (int k = 0; k < 5 && k < log_b.size(); k++) chk("b_frame_byte", {24'b0, log_b[k]}, {24'b0, exp_b[k]});
    chk("b_frames_done", {16'b0, fcb}, 32'd1);

    // Randomized traffic: back-pressure, payload churn, triggers, enable drops, resets.
    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 9) != 0);
      trig  = ($urandom_range(0, 14) == 0);
      rdy   = ($urandom_range(0, 9) < 7);
      pay_a = 16'($urandom);
      pay_b = 24'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_logger.md
FRAME_LOGGER -- requirements
Module: frame_logger

Interface
REQ-001 Parameter NUM_BYTES, default 7: payload byte count per frame, range 1..250.
REQ-002 Parameter UART_DATA_SIZE, default 8: byte width, fixed at 8.
REQ-003 Parameter TICKS, default 60000000: idle clock cycles between periodic frames, at least 2.
REQ-004 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-005 Parameter ENABLE_CHECKSUM, default 1: 1 appends a checksum byte, 0 omits it.
REQ-006 Parameter PERIODIC, default 1: 1 enables timer-started frames, 0 means trigger-only.
REQ-007 i_clock  input  1  sole clock; all logic on the rising edge.
REQ-008 i_reset  input  1  synchronous, active-high reset.
REQ-009 i_enable  input  1  high permits new frames to start.
REQ-010 i_trigger  input  1  single-cycle request for an immediate frame.
REQ-011 i_payload  input  NUM_BYTES*8  payload; byte k = bits [8k+7:8k].
REQ-012 i_txReady  input  1  UART transmitter accepts o_txData this cycle.
REQ-013 o_txData  output  8  current frame byte.
REQ-014 o_txValid  output  1  o_txData valid.
REQ-015 o_busy  output  1  frame in progress.
REQ-016 o_frameCount  output  16  completed frames, wraps 16'hFFFF to 0.

Function
REQ-017 Frame order: idx 0 SYNC_BYTE; idx 1 NUM_BYTES[7:0]; idx 2..NUM_BYTES+1 payload bytes 0..NUM_BYTES-1; idx NUM_BYTES+2 checksum (ENABLE_CHECKSUM=1 only).
REQ-018 Checksum shall be the XOR of the length byte and all captured payload bytes; SYNC_BYTE is excluded.
REQ-019 States: IDLE, SEND, END; no other state is reachable, and any illegal encoding shall return to IDLE.
REQ-020 In IDLE with i_enable=1, the period counter increments each cycle; with i_enable=0 it is held at 0.
REQ-021 Start condition in IDLE: i_enable=1 and (i_trigger=1, or pending trigger=1, or PERIODIC=1 and counter=TICKS-1).
REQ-022 On the start edge: capture i_payload into a snapshot, clear the counter and pending flag, load idx 0, and enter SEND with o_txValid=1, o_txData=SYNC_BYTE, o_busy=1 (1-cycle latency).
REQ-023 Transmitted bytes come only from the snapshot; i_payload changes during a frame shall not affect it.
REQ-024 Handshake in SEND: a byte transfers on a cycle where o_txValid=1 and i_txReady=1; o_txData and o_txValid stay stable until then.
REQ-025 After a transfer, o_txData advances to the next byte on the next cycle with o_txValid held at 1; no bubble between bytes.
REQ-026 After the last byte transfers: enter END with o_txValid=0; END lasts one cycle, increments o_frameCount, then enters IDLE with o_busy=0.
REQ-027 An i_trigger that arrives while in SEND or END sets the pending flag (one-deep; further triggers merge).
REQ-028 i_enable falling mid-frame shall not abort the frame; the pending flag is cleared whenever i_enable=0.
REQ-029 Simultaneous timer expiry and i_trigger shall start exactly one frame and leave the pending flag 0.
REQ-030 The counter does not run in SEND or END; the next period is measured from the return to IDLE.

Reset
REQ-031 i_reset=1 at any edge: state IDLE, o_txValid=0, o_txData=8'h00, o_busy=0, o_frameCount=0, counter=0, pending=0, byte index=0.
REQ-032 Reset mid-frame abandons the frame; the partial frame is not counted, and after release a new frame starts from idx 0.

Verification (NUM_BYTES=2, TICKS=4, SYNC_BYTE=8'hA5, i_payload=16'h1234, i_txReady=1 unless stated)
REQ-033 Periodic, checksum on -> bytes A5,02,34,12,24 on consecutive cycles; o_frameCount=1; next frame starts 4 idle cycles after return to IDLE.
REQ-034 ENABLE_CHECKSUM=0, PERIODIC=0, one i_trigger pulse -> A5,02,34,12 only; no further frame without another trigger.
REQ-035 Ready low 3 cycles on byte 34 -> 34 held with o_txValid=1 for 4 cycles; i_payload changed to 16'hFFFF mid-frame -> 12 and checksum 24 still sent.
REQ-036 Two i_trigger pulses during SEND -> exactly one extra frame immediately after END; o_frameCount=2.
REQ-037 i_reset during byte 34 -> o_txValid=0 next cycle, o_frameCount=0; the next frame begins with A5.
REQ-038 i_enable=0 for 10 cycles -> no frames and counter=0; i_trigger while disabled -> no frame after re-enable.
